// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the register-scan FSM state type.
`timescale 1ns/1ps
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } scan_state_t;
endpackage

// File: rtl/reg_idx_counter.sv
// Register index walker for reg_scan_reader: loads a first/last pair, increments with
// wrap at NUM_REGS-1 -> 0, and flags when the current index is the last one.
`timescale 1ns/1ps
module reg_idx_counter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              inc,
  output logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] next_idx,
  output logic              is_last
);
  logic [ADDR_W-1:0] last_q;

  // Wrap explicitly so NUM_REGS need not be a power of two.
  assign next_idx = (idx == ADDR_W'(NUM_REGS - 1)) ? '0 : idx + ADDR_W'(1);
  assign is_last  = (idx == last_q);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      last_q <= '0;
    end else if (load) begin
      idx    <= first_idx;
      last_q <= last_idx;
    end else if (inc) begin
      idx    <= next_idx;
    end
  end
endmodule

// File: rtl/reg_scan_reader.sv
// Debug read master: walks a register-index range and streams {index, data} words.
// Optional build macro REG_SCAN_CHECKSUM_EN adds an XOR checksum of accepted words.
`timescale 1ns/1ps
module reg_scan_reader
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic              busy,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done
`ifdef REG_SCAN_CHECKSUM_EN
  , output logic [DATA_W-1:0] checksum
`endif
);
  scan_state_t       state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] next_idx;
  logic              is_last;
  logic              cnt_load;
  logic              cnt_inc;
  logic              accept;

  // Abort wins over a same-cycle handshake, so an aborted word is never counted as accepted.
  assign accept   = (state == SEND) && out_valid && out_ready && !abort;
  assign cnt_load = (state == IDLE) && start;
  assign cnt_inc  = accept && !out_last;
  assign busy     = (state != IDLE);

  reg_idx_counter #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .inc       (cnt_inc),
    .idx       (idx),
    .next_idx  (next_idx),
    .is_last   (is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else if (abort && state != IDLE) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rd_addr <= first_idx;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          out_data  <= rd_data;
          out_idx   <= idx;
          out_last  <= is_last;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (accept) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rd_addr <= next_idx;
              state   <= ISSUE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REG_SCAN_CHECKSUM_EN
  // Cleared on an accepted start; otherwise folds in each accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        checksum <= '0;
    else if (cnt_load) checksum <= '0;
    else if (accept)   checksum <= checksum ^ out_data;
  end
`endif
endmodule

// File: tb/tb_reg_scan_reader.sv
// Directed self-checking bench for reg_scan_reader with a behavioural register file.
// Define REG_SCAN_CHECKSUM_EN to also exercise the checksum output.
`timescale 1ns/1ps
module tb_reg_scan_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, out_ready;
  logic [4:0]  first_idx, last_idx;
  logic        busy, out_valid, out_last, done;
  logic [4:0]  rd_addr, out_idx;
  logic [31:0] rd_data, out_data;
`ifdef REG_SCAN_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  logic [31:0] regs [32];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Register file model: index 0 always reads as zero.
  always_comb begin
    rd_data = '0;
    if (rd_addr != 5'd0) rd_data = regs[rd_addr];
  end

  reg_scan_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .busy      (busy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
`ifdef REG_SCAN_CHECKSUM_EN
    , .checksum (checksum)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [4:0] f, input logic [4:0] l);
    @(negedge clk);
    first_idx = f;
    last_idx  = l;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({tag, " valid timeout"}, 64'd0, 64'd1);
  endtask

  // Checks the presented word, then steps past the accepting edge (out_ready assumed high).
  task automatic expect_word(input string tag, input logic [4:0] i, input logic [31:0] d,
                             input logic l);
    wait_valid(tag);
    check({tag, " idx"},  64'(out_idx),  64'(i));
    check({tag, " data"}, 64'(out_data), 64'(d));
    check({tag, " last"}, 64'(out_last), 64'(l));
    @(negedge clk);
  endtask

  task automatic expect_done(input string tag);
    check({tag, " done pulse"}, 64'(done), 64'd1);
    @(negedge clk);
    check({tag, " done end"}, 64'({done, busy}), 64'd0);
  endtask

  initial begin
    int seen_done;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 | 32'(i);
    regs[0]   = 32'hDEAD_BEEF;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    first_idx = '0;
    last_idx  = '0;
    rst_n     = 1'b0;
    #1;
    check("reset outputs", 64'({busy, out_valid, out_last, done, rd_addr, out_idx, out_data}),
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: plain 1..4 scan
    regs[1] = 32'h11; regs[2] = 32'h22; regs[3] = 32'h33; regs[4] = 32'h44;
    pulse_start(5'd1, 5'd4);
    check("t1 busy", 64'(busy), 64'd1);
    check("t1 rd_addr", 64'(rd_addr), 64'd1);
    expect_word("t1 w1", 5'd1, 32'h11, 1'b0);
    expect_word("t1 w2", 5'd2, 32'h22, 1'b0);
    expect_word("t1 w3", 5'd3, 32'h33, 1'b0);
    expect_word("t1 w4", 5'd4, 32'h44, 1'b1);
`ifdef REG_SCAN_CHECKSUM_EN
    check("t1 checksum", 64'(checksum), 64'h44);
`endif
    expect_done("t1");

    // 2: wrapping range 30..1
    regs[30] = 32'hA; regs[31] = 32'hB;
    pulse_start(5'd30, 5'd1);
    expect_word("t2 w30", 5'd30, 32'hA,  1'b0);
    expect_word("t2 w31", 5'd31, 32'hB,  1'b0);
    expect_word("t2 w0",  5'd0,  32'h0,  1'b0);
    expect_word("t2 w1",  5'd1,  32'h11, 1'b1);
    expect_done("t2");

    // 3: single word with a 5-cycle stall
    regs[7]   = 32'h77;
    out_ready = 1'b0;
    pulse_start(5'd7, 5'd7);
    wait_valid("t3");
    for (int c = 0; c < 5; c++) begin
      check("t3 stall hold", 64'({out_valid, out_last, out_idx, out_data}),
            64'({1'b1, 1'b1, 5'd7, 32'h77}));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t3 valid dropped", 64'(out_valid), 64'd0);
    expect_done("t3");

    // 4: abort at idx 2, with a same-cycle ready, then a fresh scan
    pulse_start(5'd1, 5'd4);
    expect_word("t4 w1", 5'd1, 32'h11, 1'b0);
    wait_valid("t4 w2");
    check("t4 w2 idx", 64'(out_idx), 64'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4 after abort", 64'({out_valid, busy, done}), 64'd0);
    seen_done = 0;
    for (int c = 0; c < 4; c++) begin
      if (done || busy) seen_done++;
      @(negedge clk);
    end
    check("t4 idle after abort", 64'(seen_done), 64'd0);
    pulse_start(5'd3, 5'd3);
    expect_word("t4 restart", 5'd3, 32'h33, 1'b1);
    expect_done("t4 restart");

    // 5a: start while busy is ignored
    pulse_start(5'd1, 5'd4);
    expect_word("t5 w1", 5'd1, 32'h11, 1'b0);
    first_idx = 5'd10;
    last_idx  = 5'd12;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    expect_word("t5 w2", 5'd2, 32'h22, 1'b0);
    expect_word("t5 w3", 5'd3, 32'h33, 1'b0);
    expect_word("t5 w4", 5'd4, 32'h44, 1'b1);
    expect_done("t5");

    // 5b: async reset mid-scan
    pulse_start(5'd1, 5'd4);
    wait_valid("t5 reset");
    #2 rst_n = 1'b0;
    #1;
    check("t5 async reset", 64'({busy, out_valid, out_last, done, rd_addr, out_idx, out_data}),
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || busy || out_valid) seen_done++;
    end
    check("t5 quiet after reset", 64'(seen_done), 64'd0);

`ifdef REG_SCAN_CHECKSUM_EN
    // 6: checksum of 0xF0 ^ 0x0F ^ 0xFF
    regs[1] = 32'hF0; regs[2] = 32'h0F; regs[3] = 32'hFF;
    pulse_start(5'd1, 5'd3);
    check("t6 cleared", 64'(checksum), 64'd0);
    expect_word("t6 w1", 5'd1, 32'hF0, 1'b0);
    expect_word("t6 w2", 5'd2, 32'h0F, 1'b0);
    check("t6 partial", 64'(checksum), 64'hFF);
    expect_word("t6 w3", 5'd3, 32'hFF, 1'b1);
    check("t6 checksum", 64'(checksum), 64'h00);
    expect_done("t6");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
